// File: rtl/mul_ctrl_pkg.sv
//------------------------------------------------------------------------------
// mul_ctrl_pkg : shared FSM encoding and iteration constants for the
//                shift-and-add multiplier controller.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mul_ctrl_pkg;

   localparam int N_ITER = 4;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t DONE = 2'd2;

   // Counter value at which the final RUN iteration completes.
   localparam logic [1:0] CNT_LAST = 2'(N_ITER - 1);

endpackage

`default_nettype wire

// File: rtl/bit4adder.sv
//------------------------------------------------------------------------------
// bit4adder : 4-bit unsigned adder with carry-in and carry-out.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bit4adder (
   input  logic       carryin,
   input  logic [3:0] X,
   input  logic [3:0] Y,
   output logic [3:0] S,
   output logic       carryout
);

   assign {carryout, S} = {1'b0, X} + {1'b0, Y} + {4'b0000, carryin};

endmodule

`default_nettype wire

// File: rtl/adder4_mul_ctrl.sv
//------------------------------------------------------------------------------
// adder4_mul_ctrl : 4x4 unsigned multiplier that sequences one 4-bit adder
//                   through four shift-and-add iterations.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module adder4_mul_ctrl
   import mul_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic [7:0] product
);

   state_t     r_state;
   logic [3:0] r_mcand;
   logic [3:0] r_mq;
   logic [3:0] r_acc_hi;
   logic [1:0] r_cnt;
   logic       r_done;
   logic [7:0] r_product;

   logic [3:0] w_y;
   logic [3:0] w_sum;
   logic       w_carry;

   assign w_y = r_mq[0] ? r_mcand : 4'd0;

   bit4adder u_adder (
      .carryin  (1'b0),
      .X        (r_acc_hi),
      .Y        (w_y),
      .S        (w_sum),
      .carryout (w_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_mcand   <= 4'd0;
         r_mq      <= 4'd0;
         r_acc_hi  <= 4'd0;
         r_cnt     <= 2'd0;
         r_done    <= 1'b0;
         r_product <= 8'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_mcand  <= a;
                  r_mq     <= b;
                  r_acc_hi <= 4'd0;
                  r_cnt    <= 2'd0;
                  r_state  <= RUN;
               end
            end
            RUN: begin
               // {carry,sum,mq} >> 1, so the carry-out lands in acc_hi[3].
               r_acc_hi <= {w_carry, w_sum[3:1]};
               r_mq     <= {w_sum[0], r_mq[3:1]};
               r_cnt    <= r_cnt + 2'd1;
               if (r_cnt == CNT_LAST) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_product <= {r_acc_hi, r_mq};
               r_done    <= 1'b1;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ready   = (r_state == IDLE);
   assign busy    = (r_state == RUN) || (r_state == DONE);
   assign done    = r_done;
   assign product = r_product;

endmodule

`default_nettype wire

// File: doc/adder4_mul_ctrl.md
ADDER4_MUL_CTRL -- requirements
Module: adder4_mul_ctrl

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 4 bits and iteration count at 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 a  input  4  multiplicand (unsigned), captured on accepted start.
REQ-006 b  input  4  multiplier (unsigned), captured on accepted start.
REQ-007 ready  output  1  high in IDLE; start accepted only when ready=1.
REQ-008 busy  output  1  high in RUN and DONE states.
REQ-009 done  output  1  one-cycle pulse, product valid.
REQ-010 product  output  8  unsigned a*b, held until the next accepted start.

Function
REQ-011 The block SHALL sequence one 4-bit adder (carry-in tied 0) to compute product by shift-and-add over 4 RUN cycles.
REQ-012 The FSM SHALL have states IDLE, RUN, DONE, encoded via the shared package.
REQ-013 IDLE: on start=1, SHALL latch mcand<=a, mq<=b, acc_hi<=0, cnt<=0, go to RUN; start=0 stays IDLE.
REQ-014 RUN, each cycle: if mq[0]=1, adder sums acc_hi+mcand, else acc_hi+0; {carry,sum,mq} shifted right 1 into {acc_hi,mq}; cnt increments.
REQ-015 RUN SHALL exit to DONE on the cycle cnt reaches 3 (4th iteration completes).
REQ-016 DONE: product<= {acc_hi,mq}, done=1 for exactly one cycle, then unconditional return to IDLE.
REQ-017 Latency: start sampled at edge T -> done high in cycle following edge T+5; next start accepted at edge T+6 earliest (no back-to-back in DONE).
REQ-018 start asserted while busy=1 SHALL be ignored (not queued); a, b changes during RUN SHALL not affect the result.
REQ-019 Adder carry-out SHALL never be dropped; product width 8 covers max 15*15=225 without overflow.
REQ-020 product SHALL update only in DONE; it holds across IDLE and RUN of a subsequent operation.
REQ-021 ready, busy SHALL be mutually exclusive and combinational decodes of state only.

Reset
REQ-022 rst_n=0 SHALL immediately force state=IDLE, ready=1, busy=0, done=0, product=0, acc_hi/mq/mcand/cnt=0, regardless of state.
REQ-023 Reset mid-RUN SHALL abandon the operation with no done pulse; operation after release starts clean.
REQ-024 First start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-025 Package mul_ctrl_pkg SHALL hold the state typedef (IDLE, RUN, DONE) and constant N_ITER=4.
REQ-026 Adder SHALL be one instantiated sub-module, bit4adder (ports carryin, X, Y, S, carryout); no other arithmetic in the controller except the 2-bit counter increment.

Verification
REQ-027 a=0x0,b=0x0,start pulse -> done after 5 cycles, product=0x00.
REQ-028 a=0xF,b=0xF -> product=0xE1 (225), done exactly one cycle.
REQ-029 a=0x5,b=0xA then a=0xA,b=0x5 back-to-back -> both product=0x32; second start accepted only when ready=1.
REQ-030 a=0x1,b=0xF, start held high through RUN, a/b changed to 0x3/0x3 mid-run -> product=0x0F, one operation only per accepted start.
REQ-031 a=0xF,b=0x1, rst_n low during 2nd RUN cycle -> no done, product=0x00, ready=1 immediately; next a=0x7,b=0x3 -> product=0x15.
